monolith_round_sequencer: RTL and testbench

Iterative controller for the Monolith permutation over the Mersenne-31 field (p = 2^31 − 1). It sits directly around one `monolith_round` instance: it feeds the round's `state_in`, consumes its `state_out`, and adds the per-round constants modulo p. It loops the state through `NUM_ROUNDS` rounds and presents the permuted state on a valid/ready output port.

---
 rtl/monolith_pkg.sv | 37 +++
 rtl/monolith_add_rc.sv | 33 +++
 rtl/monolith_round_sequencer.sv | 99 +++++++++
 tb/tb_monolith_round_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monolith_pkg.sv
// Shared definitions for the Monolith permutation over the Mersenne-31 field:
// the modulus, sizes, the per-round constant table and the sequencer state encoding.
package monolith_pkg;

  localparam logic [30:0] P          = 31'h7FFFFFFF;
  localparam int          NUM_ROUNDS = 6;
  localparam int          STATE_SIZE = 16;
  localparam int          RC_IDX_W   = (NUM_ROUNDS > 2) ? $clog2(NUM_ROUNDS - 1) : 1;

  typedef bit [30:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // The final round adds no constant, so the table has NUM_ROUNDS-1 rows.
  localparam word_t RC [0:NUM_ROUNDS-2][0:STATE_SIZE-1] = '{
    '{31'h7FFFFFFE, 31'h00000000, 31'h02000000, 31'h03000000, 31'h04000000, 31'h05000000,
      31'h06000000, 31'h07000000, 31'h08000000, 31'h09000000, 31'h0A000000, 31'h0B000000,
      31'h0C000000, 31'h0D000000, 31'h0E000000, 31'h0F000000},
    '{31'h00000002, 31'h00000000, 31'h02000001, 31'h03000001, 31'h04000001, 31'h05000001,
      31'h06000001, 31'h07000001, 31'h08000001, 31'h09000001, 31'h0A000001, 31'h0B000001,
      31'h0C000001, 31'h0D000001, 31'h0E000001, 31'h0F000001},
    '{31'h00000001, 31'h00000000, 31'h02000002, 31'h03000002, 31'h04000002, 31'h05000002,
      31'h06000002, 31'h07000002, 31'h08000002, 31'h09000002, 31'h0A000002, 31'h0B000002,
      31'h0C000002, 31'h0D000002, 31'h0E000002, 31'h0F000002},
    '{31'h00000001, 31'h00000000, 31'h02000003, 31'h03000003, 31'h04000003, 31'h05000003,
      31'h06000003, 31'h07000003, 31'h08000003, 31'h09000003, 31'h0A000003, 31'h0B000003,
      31'h0C000003, 31'h0D000003, 31'h0E000003, 31'h0F000003},
    '{31'h00000000, 31'h00000000, 31'h02000004, 31'h03000004, 31'h04000004, 31'h05000004,
      31'h06000004, 31'h07000004, 31'h08000004, 31'h09000004, 31'h0A000004, 31'h0B000004,
      31'h0C000004, 31'h0D000004, 31'h0E000004, 31'h0F000004}
  };

endpackage

// File: rtl/monolith_add_rc.sv
// Word-wise addition of one round's constants modulo p = 2^31-1.
// Purely combinational so a sponge wrapper can reuse it alongside the sequencer.
module monolith_add_rc
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = monolith_pkg::STATE_SIZE,
  parameter int RND_W      = 3
) (
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state,
  input  logic [RND_W-1:0]                      rnd,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] sum
);

  // One conditional subtract suffices because both operands are at most p.
  function automatic logic [WORD_WIDTH-1:0] add_mod(input logic [WORD_WIDTH-1:0] a,
                                                    input logic [WORD_WIDTH-1:0] b);
    logic [WORD_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[WORD_WIDTH-1:0];
  endfunction

  logic [RC_IDX_W-1:0] idx;

  always_comb begin
    idx = (rnd < RND_W'(NUM_ROUNDS - 1)) ? RC_IDX_W'(rnd) : '0;
    for (int i = 0; i < STATE_SIZE; i++) begin
      sum[i] = add_mod(state[i], RC[idx][i]);
    end
  end

endmodule

// File: rtl/monolith_round_sequencer.sv
// Iterates the state through an external monolith_round NUM_ROUNDS times,
// adding round constants between iterations, with valid/ready ports on both sides.
module monolith_round_sequencer
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH    = 31,
  parameter int STATE_SIZE    = monolith_pkg::STATE_SIZE,
  parameter int NUM_ROUNDS    = monolith_pkg::NUM_ROUNDS,
  parameter int ROUND_LATENCY = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] in_state,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_state,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_in,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_out,
  input  logic                                  round_valid,
  output logic                                  busy,
  output logic                                  err
);

  localparam int RND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int LAT_W = (ROUND_LATENCY > 1) ? $clog2(ROUND_LATENCY) : 1;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(ROUND_LATENCY - 1);

  logic [1:0]                            fsm;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_reg;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] rc_sum;
  logic [RND_W-1:0]                      rnd;
  logic [LAT_W-1:0]                      lat_cnt;
  logic                                  last_rnd;

  monolith_add_rc #(
    .WORD_WIDTH (WORD_WIDTH),
    .STATE_SIZE (STATE_SIZE),
    .RND_W      (RND_W)
  ) u_add_rc (
    .state (round_out),
    .rnd   (rnd),
    .sum   (rc_sum)
  );

  assign last_rnd  = (rnd == RND_W'(NUM_ROUNDS - 1));
  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_state = state_reg;
  assign round_in  = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      state_reg <= '0;
      rnd       <= '0;
      lat_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_state;
            rnd       <= '0;
            lat_cnt   <= LAT_RELOAD;
            fsm       <= RUN;
          end
        end
        RUN: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            // Capture proceeds even without round_valid; the fault is only recorded.
            if (!round_valid) err <= 1'b1;
            state_reg <= last_rnd ? round_out : rc_sum;
            if (last_rnd) begin
              fsm <= DONE;
            end else begin
              rnd     <= rnd + RND_W'(1);
              lat_cnt <= LAT_RELOAD;
            end
          end
        end
        DONE: begin
          if (out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monolith_round_sequencer.sv
// Directed bench for monolith_round_sequencer driving an identity round stub,
// so every result is the input plus the column sums of the round constants mod p.
`timescale 1ns/1ps
module tb_monolith_round_sequencer;

  localparam int W = 31;
  localparam int N = 16;
  localparam logic [30:0] PM = 31'h7FFFFFFF;

  typedef logic [N-1:0][W-1:0] st_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, busy, err, round_valid;
  logic stub_fault;
  st_t  in_state, out_state, round_in, round_out;
  st_t  stub_p1, stub_p2;
  logic [1:0] fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  monolith_round_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .round_in    (round_in),
    .round_out   (round_out),
    .round_valid (round_valid),
    .busy        (busy),
    .err         (err)
  );

  // Identity round: the sequencer's state_reg is the first of three register
  // boundaries, so round_out is ready for the capture on the third edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_p1 <= '0;
      stub_p2 <= '0;
      fill    <= '0;
    end else begin
      stub_p1 <= round_in;
      stub_p2 <= stub_p1;
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end
  assign round_out   = stub_p2;
  assign round_valid = (fill == 2'd2) && !stub_fault;

  // Column sums of RC rows 0..4, derived by hand from the table.
  function automatic logic [30:0] col_sum(input int i);
    if (i == 0) return 31'd3;
    if (i == 1) return 31'd0;
    return 31'(5 * i * (1 << 24) + 10);
  endfunction

  function automatic st_t expect_of(input st_t s);
    st_t e;
    longint t;
    for (int i = 0; i < N; i++) begin
      t = (longint'(s[i]) + longint'(col_sum(i))) % longint'(PM);
      e[i] = W'(t);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    stub_fault = 1'b0;
    in_state = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input st_t s);
    in_state = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    stub_fault = 1'b0;
    in_state = '0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (out_state !== '0) begin errors++; $display("FAIL reset_out_state: got %h want 0", out_state); end
    checks++; if (round_in !== '0) begin errors++; $display("FAIL reset_round_in: got %h want 0", round_in); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int k;
    st_t a;
    apply_reset();
    a = '0;
    send(a);
    wait_out(k);
    checks++; if (k !== 18) begin errors++; $display("FAIL basic_latency: got %0d want 18", k); end
    checks++; if (out_state !== expect_of(a)) begin errors++; $display("FAIL basic_state: got %h want %h", out_state, expect_of(a)); end
    checks++; if (out_state[2] !== 31'h0A00000A) begin errors++; $display("FAIL basic_word2: got %h want 0a00000a", out_state[2]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_wrap();
    int k;
    st_t a;
    apply_reset();
    a = '0;
    a[0] = 31'h7FFFFFFE;
    a[1] = 31'h7FFFFFFF;
    for (int i = 2; i < N; i++) a[i] = W'(i);
    send(a);
    wait_out(k);
    checks++; if (out_state[0] !== 31'h00000002) begin errors++; $display("FAIL wrap_word0: got %h want 00000002", out_state[0]); end
    checks++; if (out_state[1] !== 31'h00000000) begin errors++; $display("FAIL wrap_word1_p: got %h want 00000000", out_state[1]); end
    checks++; if (out_state !== expect_of(a)) begin errors++; $display("FAIL wrap_state: got %h want %h", out_state, expect_of(a)); end
  endtask

  task automatic test_backpressure();
    int k;
    st_t a, snap;
    apply_reset();
    out_ready = 1'b0;
    a = '0;
    for (int i = 0; i < N; i++) a[i] = W'(i * 32'h00111111);
    send(a);
    wait_out(k);
    snap = out_state;
    checks++; if (k !== 18) begin errors++; $display("FAIL bp_latency: got %0d want 18", k); end
    checks++; if (snap !== expect_of(a)) begin errors++; $display("FAIL bp_state: got %h want %h", snap, expect_of(a)); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: cycle %0d got %b want 0", c, in_ready); end
      checks++; if (out_state !== snap) begin errors++; $display("FAIL bp_hold_state: cycle %0d got %h want %h", c, out_state, snap); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int k;
    st_t a, b;
    apply_reset();
    a = '0;
    b = '0;
    for (int i = 2; i < N; i++) begin
      a[i] = W'(i * 32'h100);
      b[i] = W'(32'h00ABCDEF + i);
    end
    b[0] = 31'h00000005;
    send(a);
    repeat (3) tick();
    in_state = b;
    in_valid = 1'b1;
    k = 3;
    while (!out_valid && k < 100) begin
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_run_busy: cycle %0d got busy=%b ready=%b want 1/0", k, busy, in_ready); end
      tick();
      k++;
    end
    checks++; if (k !== 18) begin errors++; $display("FAIL b2b_first_latency: got %0d want 18", k); end
    checks++; if (out_state !== expect_of(a)) begin errors++; $display("FAIL b2b_first_state: got %h want %h", out_state, expect_of(a)); end
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ready=%b busy=%b want 1/0", in_ready, busy); end
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
    wait_out(k);
    checks++; if (k !== 18) begin errors++; $display("FAIL b2b_second_latency: got %0d want 18", k); end
    checks++; if (out_state !== expect_of(b)) begin errors++; $display("FAIL b2b_second_state: got %h want %h", out_state, expect_of(b)); end
  endtask

  task automatic test_reset_mid_run();
    int k;
    st_t a, b;
    apply_reset();
    a = '0;
    b = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = W'(32'h01234567 + i);
      b[i] = W'(32'h00000100 * i);
    end
    send(a);
    repeat (7) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_flags: got valid=%b busy=%b want 0/0", out_valid, busy); end
    checks++; if (round_in !== '0) begin errors++; $display("FAIL midrst_round_in: got %h want 0", round_in); end
    tick();
    reset = 1'b0;
    send(b);
    wait_out(k);
    checks++; if (k !== 18) begin errors++; $display("FAIL midrst_latency: got %0d want 18", k); end
    checks++; if (out_state !== expect_of(b)) begin errors++; $display("FAIL midrst_state: got %h want %h", out_state, expect_of(b)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err); end
  endtask

  task automatic test_stub_fault();
    int k;
    st_t a;
    apply_reset();
    stub_fault = 1'b1;
    a = '0;
    for (int i = 0; i < N; i++) a[i] = W'(32'h00000777 * (i + 1));
    send(a);
    tick();
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fault_err_early: got %b want 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_err_first_capture: got %b want 1", err); end
    wait_out(k);
    checks++; if (k + 3 !== 18) begin errors++; $display("FAIL fault_latency: got %0d want 18", k + 3); end
    checks++; if (out_state !== expect_of(a)) begin errors++; $display("FAIL fault_state: got %h want %h", out_state, expect_of(a)); end
    stub_fault = 1'b0;
    tick();
    send(a);
    wait_out(k);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_err_sticky: got %b want 1", err); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fault_err_cleared: got %b want 0", err); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_stub_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
